// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and state encoding for the PWM ramp controller
package pwm_pkg;
   localparam int DUTY_W = 8;
   localparam int SPEED_TO_DUTY = 36;
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RAMP_UP   = 2'd1,
      RAMP_DOWN = 2'd2,
      HOLD      = 2'd3
   } state_t;
endpackage

// File: rtl/pwm_ramp_tick.sv
// pwm_ramp_tick: step-interval prescaler, free-running only while a ramp is active
module pwm_ramp_tick #(
   parameter int TICK_DIV = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic tick
);
   localparam int CW = $clog2(TICK_DIV);
   logic [CW-1:0] cnt;
   assign tick = run && cnt == CW'(TICK_DIV - 1);
   // count while running, wrap on tick, park at zero otherwise
   always_ff @(posedge clk) begin
      if (rst || !run) cnt <= '0;
      else cnt <= tick ? '0 : cnt + 1'b1;
   end
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: soft-start/soft-stop ramp of the PWM duty toward the selected speed
module pwm_ramp_ctrl #(
   parameter int DUTY_W   = pwm_pkg::DUTY_W,
   parameter int TICK_DIV = 256,
   parameter int STEP     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [2:0]        speed,
   output logic [DUTY_W-1:0] duty,
   output logic              load,
   output logic              running,
   output logic              at_target,
   output logic [1:0]        state
);
   import pwm_pkg::*;
   localparam logic [DUTY_W-1:0] STEP_D = DUTY_W'(STEP);
   logic              enable_r;
   logic [2:0]        speed_r;
   logic [DUTY_W-1:0] target_r;
   logic [DUTY_W-1:0] duty_nxt;
   logic              tick;
   state_t            st;
   state_t            st_nxt;
   assign target_r  = enable_r ? DUTY_W'(speed_r) * DUTY_W'(SPEED_TO_DUTY) : '0;
   assign running   = st != IDLE;
   assign at_target = duty == target_r;
   assign state     = st;
   // a step only moves toward the target, so a stale direction can never overshoot it
   assign duty_nxt =
      (tick && st == RAMP_UP && duty < target_r)   ? ((target_r - duty > STEP_D) ? duty + STEP_D : target_r) :
      (tick && st == RAMP_DOWN && duty > target_r) ? ((duty - target_r > STEP_D) ? duty - STEP_D : target_r) :
      duty;
   pwm_ramp_tick #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .run  (st == RAMP_UP || st == RAMP_DOWN),
      .tick (tick)
   );
   // register the raw pins so the target is derived from stable values
   always_ff @(posedge clk) begin
      if (rst) begin
         enable_r <= 1'b0;
         speed_r  <= '0;
      end else begin
         enable_r <= enable;
         speed_r  <= speed;
      end
   end
   // next state: direction follows the sign of target minus duty
   always_comb begin
      st_nxt = st;
      st_nxt = (st == IDLE)      ? ((target_r != '0) ? RAMP_UP : IDLE) :
               (duty < target_r) ? RAMP_UP :
               (duty > target_r) ? RAMP_DOWN :
               (duty == '0)      ? IDLE : HOLD;
   end
   // state register
   always_ff @(posedge clk) begin
      if (rst) st <= IDLE;
      else st <= st_nxt;
   end
   // duty register; load marks exactly the cycles where a new duty appears
   always_ff @(posedge clk) begin
      if (rst) begin
         duty <= '0;
         load <= 1'b0;
      end else begin
         duty <= duty_nxt;
         load <= duty_nxt != duty;
      end
   end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: vector table, directed corner sequences and random run against a reference model
module tb_pwm_ramp_ctrl;
   localparam int TD = 4;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic [2:0] speed = 3'd0;
   logic [7:0] duty;
   logic       load;
   logic       running;
   logic       at_target;
   logic [1:0] state;
   int nchk = 0;
   int nerr = 0;
   pwm_ramp_ctrl #(.TICK_DIV(TD)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .speed     (speed),
      .duty      (duty),
      .load      (load),
      .running   (running),
      .at_target (at_target),
      .state     (state)
   );
   always #5 clk = ~clk;
   // reference: duty walks toward the target STEP at a time every TD ramp cycles
   typedef struct {
      int du;
      int st;
      int ph;
      int en;
      int sp;
      bit ld;
   } mdl_t;
   mdl_t m = '{0, 0, 0, 0, 0, 1'b0};
   function automatic int imin(int a, int b);
      return a < b ? a : b;
   endfunction
   function automatic int imax(int a, int b);
      return a > b ? a : b;
   endfunction
   function automatic mdl_t step(mdl_t c, bit r, bit e, int s);
      mdl_t n;
      int   tgt;
      bit   ramping;
      bit   tk;
      n = c;
      if (r) begin
         n = '{0, 0, 0, 0, 0, 1'b0};
         return n;
      end
      tgt = c.en != 0 ? c.sp * 36 : 0;
      ramping = c.st == 1 || c.st == 2;
      tk = ramping && c.ph == TD - 1;
      if (tk && c.st == 1 && c.du < tgt) n.du = imin(c.du + 4, tgt);
      if (tk && c.st == 2 && c.du > tgt) n.du = imax(c.du - 4, tgt);
      n.ld = n.du != c.du;
      if (c.st == 0) n.st = tgt > 0 ? 1 : 0;
      else if (c.du < tgt) n.st = 1;
      else if (c.du > tgt) n.st = 2;
      else n.st = c.du == 0 ? 0 : 3;
      n.ph = (ramping && !tk) ? c.ph + 1 : 0;
      n.en = e;
      n.sp = s;
      return n;
   endfunction
   always @(posedge clk) m <= step(m, rst, enable, int'(speed));
   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
      chk("model_duty", int'(duty), m.du);
      chk("model_load", int'(load), int'(m.ld));
      chk("model_state", int'(state), m.st);
      chk("model_running", int'(running), int'(m.st != 0));
      chk("model_at_target", int'(at_target), int'(m.du == (m.en != 0 ? m.sp * 36 : 0)));
   endtask
   task automatic wait_du(input string name, input int v, input int budget);
      for (int i = 0; i < budget && m.du != v; i++) cyc();
      chk(name, int'(duty), v);
   endtask
   task automatic wait_st(input string name, input int s, input int budget);
      for (int i = 0; i < budget && m.st != s; i++) cyc();
      chk(name, int'(state), s);
   endtask
   typedef struct {
      bit r;
      bit e;
      int s;
      int n;
      int duty;
      int st;
      bit ld;
      bit at;
   } vec_t;
   vec_t vt[9];
   initial begin
      int nl;
      vt[0] = '{1'b1, 1'b1, 7, 2, 0, 0, 1'b0, 1'b1};
      vt[1] = '{1'b0, 1'b1, 7, 1, 0, 0, 1'b0, 1'b0};
      vt[2] = '{1'b0, 1'b1, 7, 1, 0, 1, 1'b0, 1'b0};
      vt[3] = '{1'b0, 1'b1, 7, 3, 0, 1, 1'b0, 1'b0};
      vt[4] = '{1'b0, 1'b1, 7, 1, 4, 1, 1'b1, 1'b0};
      vt[5] = '{1'b0, 1'b1, 7, 1, 4, 1, 1'b0, 1'b0};
      vt[6] = '{1'b0, 1'b1, 7, 3, 8, 1, 1'b1, 1'b0};
      vt[7] = '{1'b1, 1'b1, 0, 1, 0, 0, 1'b0, 1'b1};
      vt[8] = '{1'b0, 1'b1, 0, 8, 0, 0, 1'b0, 1'b1};
      for (int i = 0; i < 9; i++) begin
         rst = vt[i].r;
         enable = vt[i].e;
         speed = 3'(vt[i].s);
         repeat (vt[i].n) cyc();
         chk($sformatf("vec%0d_duty", i), int'(duty), vt[i].duty);
         chk($sformatf("vec%0d_state", i), int'(state), vt[i].st);
         chk($sformatf("vec%0d_load", i), int'(load), int'(vt[i].ld));
         chk($sformatf("vec%0d_at_target", i), int'(at_target), int'(vt[i].at));
         chk($sformatf("vec%0d_running", i), int'(running), int'(vt[i].st != 0));
      end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      enable = 1'b1;
      speed = 3'd7;
      nl = 0;
      for (int i = 0; i < 63 * TD + 20 && m.st != 3; i++) begin
         cyc();
         if (load) nl++;
      end
      chk("soft_start_loads", nl, 63);
      chk("soft_start_duty", int'(duty), 252);
      chk("soft_start_state", int'(state), 3);
      chk("soft_start_at_target", int'(at_target), 1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      wait_du("redirect_reach100", 100, 200);
      speed = 3'd2;
      wait_st("redirect_hold", 3, 200);
      chk("redirect_duty", int'(duty), 72);
      speed = 3'd4;
      repeat (3) cyc();
      wait_st("hold144_state", 3, 200);
      chk("hold144_duty", int'(duty), 144);
      enable = 1'b0;
      repeat (3) cyc();
      wait_st("soft_stop_idle", 0, 300);
      chk("soft_stop_duty", int'(duty), 0);
      chk("soft_stop_running", int'(running), 0);
      enable = 1'b1;
      speed = 3'd7;
      wait_du("midreset_reach60", 60, 200);
      rst = 1'b1;
      cyc();
      chk("midreset_duty", int'(duty), 0);
      chk("midreset_state", int'(state), 0);
      chk("midreset_load", int'(load), 0);
      rst = 1'b0;
      for (int i = 0; i < 20 && !load; i++) cyc();
      chk("restart_first_step", int'(duty), 4);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(31) == 0) begin
            enable = 1'($urandom_range(3) != 0);
            speed = 3'($urandom_range(7));
         end
         rst = $urandom_range(499) == 0;
         cyc();
      end
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Soft-start / soft-stop sequencer placed in front of the PWM core in the tt_um top level. It turns the raw 3-bit speed selection and enable into a gradually ramped 8-bit duty value. It updates that value on a programmable step interval and strobes the PWM core each time the value changes. Abrupt speed changes never reach the PWM output as duty steps larger than `STEP`.

## Interface

Parameters:
- `DUTY_W`, 8: duty width.
- `TICK_DIV`, 256: `clk` cycles per ramp step. Minimum is 2.
- `STEP`, 4: duty increment per ramp step. Must divide 36.

Ports:
- `clk` (in, 1): single clock. All logic is on the rising edge.
- `rst` (in, 1): synchronous, active-high reset.
- `enable` (in, 1): run request.
- `speed` (in, 3): speed selection, 0..7.
- `duty` (out, `DUTY_W`): current duty value to the PWM core.
- `load` (out, 1): one-cycle strobe. It is high in exactly the cycles where `duty` shows a new value.
- `running` (out, 1): high in every state except IDLE.
- `at_target` (out, 1): high when `duty` equals `target_r`.
- `state` (out, 2): IDLE=0, RAMP_UP=1, RAMP_DOWN=2, HOLD=3.

## Operation

- **Input registers.** `enable` and `speed` are registered every cycle into `enable_r` and `speed_r`.
- **Target.** `target_r` = `enable_r` ? `speed_r`×36 : 0. Range is 0..252 and always a multiple of 4.
- **Prescaler.**
  - Counts 0..`TICK_DIV`−1 only while in RAMP_UP or RAMP_DOWN. It is held at 0 in IDLE and HOLD.
  - `tick` is high when the count equals `TICK_DIV`−1 in a ramp state. The count then wraps to 0.
  - A direction change between RAMP_UP and RAMP_DOWN does not clear the count.
- **Step on `tick`.**
  - RAMP_UP: `duty` ← min(`duty`+`STEP`, `target_r`).
  - RAMP_DOWN: `duty` ← max(`duty`−`STEP`, `target_r`), with no underflow below 0.
  - `load` is 1 in the same cycle the new `duty` appears. `load` is 0 when `duty` is unchanged.
- **FSM.** Transitions are evaluated every cycle from registered values, in priority order:
  - IDLE → RAMP_UP when `target_r` > 0.
  - RAMP_UP/RAMP_DOWN/HOLD: if `duty` < `target_r` → RAMP_UP; else if `duty` > `target_r` → RAMP_DOWN; else if `duty`=0 → IDLE; else → HOLD.
  - A target change mid-ramp redirects at the next cycle. Duty never jumps.
- **Disable.** Dropping `enable` forces the target to 0. The block ramps down to 0 and then enters IDLE; `running` falls in that cycle.
  - `enable`=1 with `speed`=0 behaves the same way.
- **Wrap-around.** `duty` never wraps past 0 or 252.
- **`at_target`** is combinational from registers.

## Timing

- **Reset values:**
  - `duty`=0, `load`=0, `running`=0, `state`=IDLE.
  - `at_target`=1, because `target_r`=0.
  - Prescaler=0, `enable_r`=0, `speed_r`=0.
- **Synchronous `rst` mid-ramp.** All of the above take effect at the next edge, with `duty` going straight to 0. `load` is not pulsed for the reset drop.
- **Input latency.** An input change is seen in `target_r` 1 cycle later. `state` responds 1 cycle after that.
- **First step.** The first duty step occurs `TICK_DIV` cycles after entering RAMP_UP from IDLE or HOLD.
- **Full ramp.** 0→252 takes 63 steps, i.e. 63×`TICK_DIV` cycles plus 2 cycles of input latency.
- **Simultaneous events.** A target change in the same cycle as `tick` steps toward the old `target_r`. The next step uses the new target.

## Structure

- **Shared package `pwm_pkg`:**
  - state encoding constants (IDLE/RAMP_UP/RAMP_DOWN/HOLD);
  - `DUTY_W`;
  - `SPEED_TO_DUTY`=36.
- **Sub-module `pwm_ramp_tick`:** the prescaler. Parameter `TICK_DIV`; inputs `clk`, `rst`, `run`; output `tick`. The FSM and duty datapath stay in `pwm_ramp_ctrl`.
- **Top-level wiring.** The tt_um top instantiates `pwm_ramp_ctrl` between the `ui_in` speed/enable pins and the PWM core's duty/load inputs.

## Test plan

All scenarios use `TICK_DIV`=4.

1. **Reset.** Assert `rst` for 2 cycles with `enable`=1, `speed`=7 → during reset `duty`=0, `load`=0, `running`=0, `at_target`=1, `state`=0.
2. **Soft start.** `enable`=1, `speed`=7 from IDLE:
   - `state`=1 two cycles later;
   - `duty` goes 4, 8, …, 252, each step 4 cycles apart with a single-cycle `load`;
   - then `state`=3 and `at_target`=1.
3. **Redirect mid-ramp.** While ramping up, change `speed` to 2 at `duty`=100 → direction flips to RAMP_DOWN. `duty` steps down to 72 and holds. Prescaler phase is continuous (steps stay 4 cycles apart).
4. **Soft stop.** From HOLD at 144, drop `enable` → `duty` ramps down by 4 to 0, then `state`=0 and `running`=0. `duty` never underflows.
5. **Mid-ramp reset.** Assert `rst` at `duty`=60 while ramping → next cycle `duty`=0, `state`=0, no `load` pulse. Ramp restarts cleanly after `rst` falls.
6. **Zero speed.** `enable`=1, `speed`=0 → block stays IDLE, `duty`=0, and `load` never asserts.
